// File: rtl/ladybird_decoder_pkg.sv
// RV32I decode definitions: opcodes, instruction class / ALU op enums, the decoded
// record and the pure decode() function used by the decode stage.
package ladybird_decoder_pkg;

  localparam int XLEN_SUPPORTED = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH, CLS_LOAD,
    CLS_STORE, CLS_OPIMM, CLS_OP, CLS_FENCE, CLS_SYSTEM, CLS_ILLEGAL
  } inst_class_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  typedef struct packed {
    inst_class_t cls;
    alu_op_t     alu_op;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        rd_we;
    logic        illegal;
  } decoded_t;

  // Shared funct3 -> ALU mapping for OP / OP-IMM; alt selects SUB / SRA.
  function automatic alu_op_t alu_f3(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic decoded_t decode(input logic [31:0] inst);
    decoded_t    d;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] imm_i;
    logic        ok;
    logic        we;
    f7    = inst[31:25];
    f3    = inst[14:12];
    imm_i = {{20{inst[31]}}, inst[31:20]};
    d        = '0;
    d.funct3 = f3;
    d.rd     = inst[11:7];
    d.rs1    = inst[19:15];
    d.rs2    = inst[24:20];
    d.alu_op = ALU_ADD;
    d.cls    = CLS_ILLEGAL;
    ok       = 1'b1;
    we       = 1'b0;
    case (inst[6:0])
      OPC_LUI: begin
        d.cls = CLS_LUI; d.imm = {inst[31:12], 12'b0}; d.rs1 = '0; we = 1'b1;
      end
      OPC_AUIPC: begin
        d.cls = CLS_AUIPC; d.imm = {inst[31:12], 12'b0}; we = 1'b1;
      end
      OPC_JAL: begin
        d.cls = CLS_JAL; we = 1'b1;
        d.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OPC_JALR: begin
        d.cls = CLS_JALR; d.imm = imm_i; we = 1'b1; ok = (f3 == 3'd0);
      end
      OPC_BRANCH: begin
        d.cls = CLS_BRANCH;
        d.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        ok    = (f3 != 3'd2) && (f3 != 3'd3);
        d.alu_op = !f3[2] ? ALU_SUB : (f3[1] ? ALU_SLTU : ALU_SLT);
      end
      OPC_LOAD: begin
        d.cls = CLS_LOAD; d.imm = imm_i; we = 1'b1;
        ok    = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
      end
      OPC_STORE: begin
        d.cls = CLS_STORE; d.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        ok    = (f3 <= 3'd2);
      end
      OPC_OPIMM: begin
        d.cls = CLS_OPIMM; d.imm = imm_i; we = 1'b1; d.alu_op = alu_f3(f3, 1'b0);
        if (f3 == 3'd1) begin
          d.imm = {27'b0, inst[24:20]}; ok = (f7 == 7'h00);
        end else if (f3 == 3'd5) begin
          d.imm    = {27'b0, inst[24:20]};
          ok       = (f7 == 7'h00) || (f7 == 7'h20);
          d.alu_op = inst[30] ? ALU_SRA : ALU_SRL;
        end
      end
      OPC_OP: begin
        d.cls = CLS_OP; we = 1'b1; d.alu_op = alu_f3(f3, inst[30]);
        ok    = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
      end
      OPC_FENCE: begin
        d.cls = CLS_FENCE; d.imm = imm_i;
      end
      OPC_SYSTEM: begin
        d.cls = CLS_SYSTEM; d.imm = imm_i;
        ok    = (inst == 32'h0000_0073) || (inst == 32'h0010_0073);
      end
      default: ok = 1'b0;
    endcase
    d.rd_we = we && (inst[11:7] != 5'd0);
    // Bad encodings keep their raw register fields but carry no side effects.
    if (!ok) begin
      d.cls = CLS_ILLEGAL; d.illegal = 1'b1; d.imm = '0; d.alu_op = ALU_ADD; d.rd_we = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/ladybird_decoder_skid.sv
// Output register plus one skid entry with valid/ready on both sides; in_ready is
// a pure register so the upstream ready path never sees downstream combinational logic.
module ladybird_skid_buffer #(
  parameter type T = logic [7:0]
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_flush,
  input  logic i_valid,
  output logic o_ready,
  input  T     i_data,
  output logic o_valid,
  input  logic i_ready,
  output T     o_data
);

  T     r_out;
  T     r_skid;
  logic r_out_vld;
  logic r_skid_vld;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out      <= '0;
      r_skid     <= '0;
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (i_flush) begin
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (!r_out_vld || i_ready) begin
      // Skid has priority; input cannot be accepted while it is full.
      if (r_skid_vld) begin
        r_out      <= r_skid;
        r_out_vld  <= 1'b1;
        r_skid_vld <= 1'b0;
      end else begin
        r_out_vld <= i_valid;
        if (i_valid) r_out <= i_data;
      end
    end else if (i_valid && !r_skid_vld) begin
      r_skid     <= i_data;
      r_skid_vld <= 1'b1;
    end
  end

  assign o_ready = !r_skid_vld;
  assign o_valid = r_out_vld;
  assign o_data  = r_out;

endmodule

// File: rtl/ladybird_decoder.sv
// RV32I decode stage: combinational decode() of the fetch word, then one registered
// stage with a skid entry so the stage sustains one word per cycle under backpressure.
module ladybird_decoder
  import ladybird_decoder_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [PC_W-1:0] i_in_pc,
  input  logic [XLEN-1:0] i_in_inst,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [PC_W-1:0] o_out_pc,
  output decoded_t        o_out_dec
);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    decoded_t        dec;
  } entry_t;

  entry_t w_in;
  entry_t w_out;

  always_comb begin
    w_in     = '0;
    w_in.pc  = i_in_pc;
    w_in.dec = decode(i_in_inst);
  end

  ladybird_skid_buffer #(.T(entry_t)) u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_flush),
    .i_valid (i_in_valid),
    .o_ready (o_in_ready),
    .i_data  (w_in),
    .o_valid (o_out_valid),
    .i_ready (i_out_ready),
    .o_data  (w_out)
  );

  assign o_out_pc  = w_out.pc;
  assign o_out_dec = w_out.dec;

endmodule

// File: tb/tb_ladybird_decoder.sv
// Directed bench for ladybird_decoder: a scoreboard of held words decoded by an
// arithmetic reference model, checked every cycle, plus hand-computed literal checks.
module tb_ladybird_decoder;
  import ladybird_decoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  decoded_t    out_dec;

  always #5 clk = ~clk;

  ladybird_decoder dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_flush     (flush),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_pc     (in_pc),
    .i_in_inst   (in_inst),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_pc    (out_pc),
    .o_out_dec   (out_dec)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } word_t;

  word_t held[$];
  word_t send_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference decode: immediates built by weighted sums, sign by subtracting 2^n.
  function automatic decoded_t model(input logic [31:0] w);
    decoded_t    d;
    logic        legal;
    logic        we;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] si;
    alu_op_t     tab [8];
    tab   = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    f3    = w[14:12];
    f7    = w[31:25];
    si    = {20'd0, w[31:20]} - (w[31] ? 32'd4096 : 32'd0);
    d        = '0;
    d.funct3 = f3;
    d.rd     = w[11:7];
    d.rs1    = w[19:15];
    d.rs2    = w[24:20];
    d.alu_op = ALU_ADD;
    legal    = 1'b1;
    we       = 1'b0;
    case (w[6:0])
      7'h37: begin d.cls = CLS_LUI; d.imm = w & 32'hFFFFF000; d.rs1 = 5'd0; we = 1'b1; end
      7'h17: begin d.cls = CLS_AUIPC; d.imm = w & 32'hFFFFF000; we = 1'b1; end
      7'h6F: begin
        d.cls = CLS_JAL; we = 1'b1;
        d.imm = ({24'd0, w[19:12]} << 12) + ({31'd0, w[20]} << 11) + ({22'd0, w[30:21]} << 1)
              - (w[31] ? 32'h0010_0000 : 32'd0);
      end
      7'h67: begin d.cls = CLS_JALR; d.imm = si; we = 1'b1; legal = (f3 == 3'd0); end
      7'h63: begin
        d.cls = CLS_BRANCH; legal = !(f3 == 3'd2 || f3 == 3'd3);
        d.imm = ({31'd0, w[7]} << 11) + ({26'd0, w[30:25]} << 5) + ({28'd0, w[11:8]} << 1)
              - (w[31] ? 32'd4096 : 32'd0);
        if (f3 == 3'd0 || f3 == 3'd1) d.alu_op = ALU_SUB;
        else if (f3 == 3'd4 || f3 == 3'd5) d.alu_op = ALU_SLT;
        else d.alu_op = ALU_SLTU;
      end
      7'h03: begin
        d.cls = CLS_LOAD; d.imm = si; we = 1'b1;
        legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      end
      7'h23: begin
        d.cls = CLS_STORE; legal = (f3 <= 3'd2);
        d.imm = ({25'd0, w[31:25]} << 5) + {27'd0, w[11:7]} - (w[31] ? 32'd4096 : 32'd0);
      end
      7'h13: begin
        d.cls = CLS_OPIMM; we = 1'b1;
        if (f3 == 3'd1) begin
          d.imm = {27'd0, w[24:20]}; d.alu_op = ALU_SLL; legal = (f7 == 7'h00);
        end else if (f3 == 3'd5) begin
          d.imm = {27'd0, w[24:20]}; legal = (f7 == 7'h00 || f7 == 7'h20);
          d.alu_op = (f7 == 7'h20) ? ALU_SRA : ALU_SRL;
        end else begin
          d.imm = si; d.alu_op = tab[f3];
        end
      end
      7'h33: begin
        d.cls = CLS_OP; we = 1'b1;
        if (f7 == 7'h00) d.alu_op = tab[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) d.alu_op = ALU_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) d.alu_op = ALU_SRA;
        else legal = 1'b0;
      end
      7'h0F: begin d.cls = CLS_FENCE; d.imm = si; end
      7'h73: begin
        d.cls = CLS_SYSTEM; d.imm = si; legal = (w == 32'h73 || w == 32'h0010_0073);
      end
      default: legal = 1'b0;
    endcase
    d.rd_we = we && (w[11:7] != 5'd0);
    if (!legal) begin
      d.cls = CLS_ILLEGAL; d.illegal = 1'b1; d.imm = '0; d.alu_op = ALU_ADD; d.rd_we = 1'b0;
    end
    return d;
  endfunction

  // Every cycle: outputs must reflect the held entries, then apply this cycle's events.
  always @(negedge clk) begin
    decoded_t exp_d;
    if (!rst) begin
      chk("out_valid", 64'(out_valid), 64'(held.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(held.size() < 2));
      if (held.size() > 0 && out_valid) begin
        exp_d = model(held[0].inst);
        chk("out_pc", 64'(out_pc), 64'(held[0].pc));
        chk("out_dec", 64'(out_dec), 64'(exp_d));
      end
    end
    if (rst || flush) held.delete();
    else begin
      if (out_valid && out_ready && held.size() > 0) void'(held.pop_front());
      if (in_valid && in_ready) held.push_back('{in_pc, in_inst});
    end
  end

  task automatic push(input logic [31:0] pc, input logic [31:0] inst);
    send_q.push_back('{pc, inst});
  endtask

  // Drive n cycles from send_q; returns #1 after the last edge.
  task automatic run(input int n, input bit ordy);
    bit acc;
    repeat (n) begin
      out_ready = ordy;
      if (send_q.size() > 0) begin
        in_valid = 1'b1; in_pc = send_q[0].pc; in_inst = send_q[0].inst;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) void'(send_q.pop_front());
    end
  endtask

  initial begin
    decoded_t dd;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_dec", 64'(out_dec), 64'd0);
    rst = 1'b0;

    dd = model(32'hFFF10093);
    chk("model_addi_imm", 64'(dd.imm), 64'hFFFFFFFF);
    dd = model(32'h008000EF);
    chk("model_jal_imm", 64'(dd.imm), 64'd8);

    push(32'h100, 32'hFFF10093);
    run(1, 1'b1);
    dd = out_dec;
    chk("addi_valid", 64'(out_valid), 64'd1);
    chk("addi_pc", 64'(out_pc), 64'h100);
    chk("addi_cls", 64'(dd.cls), 64'(CLS_OPIMM));
    chk("addi_alu", 64'(dd.alu_op), 64'(ALU_ADD));
    chk("addi_rd", 64'(dd.rd), 64'd1);
    chk("addi_rs1", 64'(dd.rs1), 64'd2);
    chk("addi_imm", 64'(dd.imm), 64'hFFFFFFFF);
    chk("addi_we_ill", {62'd0, dd.rd_we, dd.illegal}, 64'b10);

    push(32'h104, 32'h008000EF);
    push(32'h108, 32'hFE512E23);
    run(1, 1'b1);
    dd = out_dec;
    chk("jal_pc", 64'(out_pc), 64'h104);
    chk("jal_imm", 64'(dd.imm), 64'd8);
    chk("jal_we", 64'(dd.rd_we), 64'd1);
    run(1, 1'b1);
    dd = out_dec;
    chk("sw_pc", 64'(out_pc), 64'h108);
    chk("sw_rs", {54'd0, dd.rs1, dd.rs2}, {54'd0, 5'd2, 5'd5});
    chk("sw_f3", 64'(dd.funct3), 64'd2);
    chk("sw_imm", 64'(dd.imm), 64'hFFFFFFFC);
    chk("sw_we", 64'(dd.rd_we), 64'd0);

    push(32'h10C, 32'h40325193);
    push(32'h110, 32'h00000000);
    push(32'h114, 32'h0000707F);
    run(1, 1'b1);
    dd = out_dec;
    chk("srai_alu", 64'(dd.alu_op), 64'(ALU_SRA));
    chk("srai_imm", 64'(dd.imm), 64'd3);
    run(1, 1'b1);
    dd = out_dec;
    chk("zero_illegal", {62'd0, dd.illegal, dd.rd_we}, 64'b10);
    chk("zero_cls", 64'(dd.cls), 64'(CLS_ILLEGAL));
    run(1, 1'b1);
    dd = out_dec;
    chk("707f_illegal", 64'(dd.illegal), 64'd1);
    run(1, 1'b1);

    // Mixed stream under intermittent backpressure.
    push(32'h120, 32'h123452B7); push(32'h124, 32'hFE209EE3);
    push(32'h128, 32'h00000073); push(32'h12C, 32'h00100073);
    push(32'h130, 32'h00200073); push(32'h134, 32'h0040A183);
    push(32'h138, 32'h0000B003); push(32'h13C, 32'h40208033);
    push(32'h140, 32'h40209033); push(32'h144, 32'h0000000F);
    push(32'h148, 32'h00001067); push(32'h14C, 32'hFFF0C637);
    for (int i = 0; i < 16; i++) run(1, (i % 3) != 2);
    run(8, 1'b1);
    chk("stream_drained", 64'(held.size() + send_q.size()), 64'd0);

    // Stall: four words, five cycles of out_ready=0.
    for (int i = 0; i < 4; i++) push(32'h200 + 32'(4 * i), 32'h00100093 + 32'(i << 20));
    run(5, 1'b0);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_out_pc", 64'(out_pc), 64'h200);
    chk("stall_held", 64'(held.size()), 64'd2);
    run(10, 1'b1);
    chk("stall_drained", 64'(held.size() + send_q.size()), 64'd0);

    // Flush with out reg and skid full and a third word offered.
    push(32'h300, 32'h00000013); push(32'h304, 32'h00000013); push(32'h308, 32'h00000013);
    run(3, 1'b0);
    chk("pre_flush_in_ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    run(1, 1'b0);
    flush = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    send_q.delete();
    run(3, 1'b1);
    push(32'h380, 32'h00000013);
    flush = 1'b1;
    run(1, 1'b1);
    flush = 1'b0;
    chk("flush_accept_dropped", 64'(out_valid), 64'd0);
    run(2, 1'b1);

    // Reset in the middle of a stall.
    push(32'h400, 32'h00000013); push(32'h404, 32'h00000013); push(32'h408, 32'h00000013);
    run(3, 1'b0);
    rst = 1'b1;
    run(2, 1'b0);
    rst = 1'b0;
    send_q.delete();
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    run(1, 1'b1);
    chk("rst_mid_no_pulse", 64'(out_valid), 64'd0);
    push(32'h500, 32'hFFF10093);
    run(1, 1'b1);
    dd = out_dec;
    chk("post_rst_pc", 64'(out_pc), 64'h500);
    chk("post_rst_imm", 64'(dd.imm), 64'hFFFFFFFF);
    run(3, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
